circ_shreg: RTL and testbench

CIRC_SHREG -- requirements
Module: circ_shreg

---
 rtl/circ_shreg_pkg.sv | 19 +
 rtl/circ_rot_step.sv | 26 ++
 rtl/circ_shreg.sv | 152 +++++++++++++++
 tb/tb_circ_shreg.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/circ_shreg_pkg.sv
// Shared definitions for the circular shift register: clog2 helper, default tap list, FSM states.
package circ_shreg_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Tap k sits at bits [k*4 +: 4]; taps 0..6 read slots 0,13,3,14,2,15,1.
    localparam logic [27:0] TAP_IDX_DEFAULT = {4'd1, 4'd15, 4'd2, 4'd14, 4'd3, 4'd13, 4'd0};

    typedef enum logic {
        IDLE = 1'b0,
        ROT  = 1'b1
    } state_t;

endpackage

// File: rtl/circ_rot_step.sv
// Combinational left rotator over the slot array: slot[i] takes slot[(i+k) mod DEPTH], k in 0..MAX_STEP.
module circ_rot_step
    import circ_shreg_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int DEPTH     = 16,
    parameter int MAX_STEP  = 5,
    localparam int AW       = clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][BIT_WIDTH-1:0] slots_i,
    input  logic [AW-1:0]                   step_i,
    output logic [DEPTH-1:0][BIT_WIDTH-1:0] slots_o
);

    always_comb begin
        slots_o = slots_i;
        for (int k = 1; k <= MAX_STEP; k++) begin
            if (step_i == AW'(k)) begin
                for (int i = 0; i < DEPTH; i++) begin
                    slots_o[AW'(i)] = slots_i[AW'((i + k) % DEPTH)];
                end
            end
        end
    end

endmodule

// File: rtl/circ_shreg.sv
// Circular shift register with multi-cycle rotate commands, insert, clear and fixed taps.
// Define CIRC_SHREG_POS_EN to build the accumulated-rotation counter (pos) and its wrap pulse.
module circ_shreg
    import circ_shreg_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int DEPTH     = 16,
    parameter int NUM_TAP   = 7,
    parameter int MAX_STEP  = 5,
    parameter logic [NUM_TAP*clog2(DEPTH)-1:0] TAP_IDX = TAP_IDX_DEFAULT,
    localparam int AW       = clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // the payload is captured there and cmd_ready stays low until its final step.
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [AW-1:0]                cmd_shamt,
    input  logic                         cmd_ins,
    input  logic                         cmd_clr,
    input  logic [BIT_WIDTH-1:0]         in_data,
    output logic [NUM_TAP*BIT_WIDTH-1:0] tap_data,
    output logic                         done,
    output logic [AW-1:0]                pos,
    output logic                         wrap,
    output state_t                       fsm_state_o
);

    localparam logic [AW-1:0] MAX_STEP_W = AW'(MAX_STEP);

    typedef logic [DEPTH-1:0][BIT_WIDTH-1:0] slots_t;

    state_t               state_q, state_d;
    slots_t               slots_q, slots_d, slots_rot;
    logic [AW-1:0]        rem_q, rem_d, cur_rem, step;
    logic                 ins_q, ins_d, cur_ins;
    logic [BIT_WIDTH-1:0] data_q, data_d, cur_data;
    logic                 done_q, done_d;
    logic                 accept, clr_go, active, last;

    assign cmd_ready   = (state_q == IDLE);
    assign accept      = cmd_valid && cmd_ready;
    assign clr_go      = accept && cmd_clr;
    assign active      = accept ? !cmd_clr : (state_q == ROT);
    assign fsm_state_o = state_q;

    // The first step runs straight from the command inputs; later steps use the captured copy.
    assign cur_rem  = (state_q == IDLE) ? cmd_shamt : rem_q;
    assign cur_ins  = (state_q == IDLE) ? cmd_ins   : ins_q;
    assign cur_data = (state_q == IDLE) ? in_data   : data_q;
    assign last     = (cur_rem <= MAX_STEP_W);
    assign step     = last ? cur_rem : MAX_STEP_W;

    circ_rot_step #(
        .BIT_WIDTH (BIT_WIDTH),
        .DEPTH     (DEPTH),
        .MAX_STEP  (MAX_STEP)
    ) u_rot (
        .slots_i (slots_q),
        .step_i  (step),
        .slots_o (slots_rot)
    );

    always_comb begin
        state_d = state_q;
        slots_d = slots_q;
        rem_d   = rem_q;
        ins_d   = ins_q;
        data_d  = data_q;
        done_d  = 1'b0;
        if (clr_go) begin
            slots_d = '0;
            done_d  = 1'b1;
        end else if (active) begin
            slots_d = slots_rot;
            if (last && cur_ins) begin
                slots_d[DEPTH-1] = cur_data;
            end
            rem_d   = cur_rem - step;
            ins_d   = cur_ins;
            data_d  = cur_data;
            done_d  = last;
            state_d = last ? IDLE : ROT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            slots_q <= '0;
            rem_q   <= '0;
            ins_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slots_q <= slots_d;
            rem_q   <= rem_d;
            ins_q   <= ins_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;

    for (genvar k = 0; k < NUM_TAP; k++) begin : g_tap
        assign tap_data[k*BIT_WIDTH +: BIT_WIDTH] = slots_q[TAP_IDX[k*AW +: AW]];
    end

`ifdef CIRC_SHREG_POS_EN
    logic [AW-1:0] pos_q, pos_d;
    logic          wrap_acc_q, wrap_acc_d, wrap_q, wrap_d;
    logic [AW:0]   pos_sum;

    // wrap_acc remembers a carry from any earlier step of the same command.
    always_comb begin
        pos_sum    = {1'b0, pos_q} + {1'b0, step};
        pos_d      = pos_q;
        wrap_acc_d = wrap_acc_q;
        wrap_d     = 1'b0;
        if (clr_go) begin
            pos_d      = '0;
            wrap_acc_d = 1'b0;
        end else if (active) begin
            pos_d      = pos_sum[AW-1:0];
            wrap_acc_d = pos_sum[AW] | ((state_q == ROT) && wrap_acc_q);
            wrap_d     = last && wrap_acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_q      <= '0;
            wrap_acc_q <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            pos_q      <= pos_d;
            wrap_acc_q <= wrap_acc_d;
            wrap_q     <= wrap_d;
        end
    end

    assign pos  = pos_q;
    assign wrap = wrap_q;
`else
    assign pos  = '0;
    assign wrap = 1'b0;
`endif

endmodule

// File: tb/tb_circ_shreg.sv
// Self-checking bench for circ_shreg: directed scenarios plus random commands against a command-level model.
module tb_circ_shreg;
    import circ_shreg_pkg::*;

    localparam int BW  = 32;
    localparam int DP  = 16;
    localparam int NT  = 7;
    localparam int MS  = 5;

    typedef logic [BW-1:0] slot_arr_t [DP];

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_shamt;
    logic              cmd_ins;
    logic              cmd_clr;
    logic [BW-1:0]     in_data;
    logic [NT*BW-1:0]  tap_data;
    logic              done;
    logic [3:0]        pos;
    logic              wrap;
    state_t            fsm_state;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    int tap_list [NT] = '{0, 13, 3, 14, 2, 15, 1};

    circ_shreg dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_shamt   (cmd_shamt),
        .cmd_ins     (cmd_ins),
        .cmd_clr     (cmd_clr),
        .in_data     (in_data),
        .tap_data    (tap_data),
        .done        (done),
        .pos         (pos),
        .wrap        (wrap),
        .fsm_state_o (fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- command-level model ----------------
    slot_arr_t m_slots;
    int        m_pos, m_left, m_step_cnt;
    bit        m_done, m_wrap;
    slot_arr_t c_start;
    int        c_pos, c_s, c_n;
    bit        c_ins;
    logic [BW-1:0] c_data;

    function automatic slot_arr_t rot(input slot_arr_t s, input int k);
        slot_arr_t r;
        for (int i = 0; i < DP; i++) r[i] = s[(i + k) % DP];
        return r;
    endfunction

    // State after j steps of the current command: cumulative rotation min(j*MS, S).
    task automatic advance(input int j);
        int amt;
        amt = (j * MS < c_s) ? j * MS : c_s;
        m_slots = rot(c_start, amt);
        m_pos   = (c_pos + amt) % DP;
        if (j == c_n) begin
            if (c_ins) m_slots[DP-1] = c_data;
            m_done = 1'b1;
            m_wrap = (c_pos + c_s >= DP);
        end
    endtask

    always @(posedge clk) begin
        m_done = 1'b0;
        m_wrap = 1'b0;
        if (!rst_n) begin
            for (int i = 0; i < DP; i++) m_slots[i] = '0;
            m_pos  = 0;
            m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            m_step_cnt++;
            advance(m_step_cnt);
        end else if (cmd_valid) begin
            if (cmd_clr) begin
                for (int i = 0; i < DP; i++) m_slots[i] = '0;
                m_pos  = 0;
                m_done = 1'b1;
            end else begin
                c_start    = m_slots;
                c_pos      = m_pos;
                c_s        = int'(cmd_shamt);
                c_ins      = cmd_ins;
                c_data     = in_data;
                c_n        = (c_s == 0) ? 1 : (c_s + MS - 1) / MS;
                m_step_cnt = 1;
                m_left     = c_n - 1;
                advance(1);
            end
        end
    end

    function automatic logic [NT*BW-1:0] exp_taps();
        logic [NT*BW-1:0] v;
        for (int k = 0; k < NT; k++) v[k*BW +: BW] = m_slots[tap_list[k]];
        return v;
    endfunction

    // ---------------- every-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("taps",  256'(tap_data), 256'(exp_taps()));
            chk("ready", 256'(cmd_ready), 256'(m_left == 0));
            chk("done",  256'(done), 256'(m_done));
`ifdef CIRC_SHREG_POS_EN
            chk("pos",   256'(pos), 256'(m_pos));
            chk("wrap",  256'(wrap), 256'(m_wrap));
`else
            chk("pos",   256'(pos), 256'(0));
            chk("wrap",  256'(wrap), 256'(0));
`endif
        end
    end

    // ---------------- driver ----------------
    // Called just after a negedge; returns just after the negedge following the accept edge.
    task automatic send(input logic [3:0] s, input logic ins, input logic clr,
                        input logic [BW-1:0] d, input int gap);
        int waited;
        cmd_valid = 1'b0;
        repeat (gap) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_shamt = s;
        cmd_ins   = ins;
        cmd_clr   = clr;
        in_data   = d;
        waited    = 0;
        while (cmd_ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 40) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: cmd_ready stayed %b, required 1", cmd_ready);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    function automatic logic [BW-1:0] tap(input int k);
        return tap_data[k*BW +: BW];
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_shamt = '0;
        cmd_ins   = 1'b0;
        cmd_clr   = 1'b0;
        in_data   = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        chk("rst_taps",  256'(tap_data), 256'(0));
        chk("rst_ready", 256'(cmd_ready), 256'(1));
        chk("rst_pos",   256'(pos), 256'(0));
        chk("rst_done",  256'(done), 256'(0));

        // Fill: slot i = i+1
        for (int i = 1; i <= DP; i++) begin
            send(4'd1, 1'b1, 1'b0, BW'(i), 0);
            chk("fill_done", 256'(done), 256'(1));
        end
        chk("fill_tap0", 256'(tap(0)), 256'(1));
        chk("fill_tap1", 256'(tap(1)), 256'(14));
        chk("fill_tap5", 256'(tap(5)), 256'(16));

        // Multi-step rotate by 12: steps 5,5,2
        send(4'd12, 1'b0, 1'b0, '0, 0);
        chk("ms_ready1", 256'(cmd_ready), 256'(0));
        @(negedge clk);
        chk("ms_ready2", 256'(cmd_ready), 256'(0));
        chk("ms_nodone", 256'(done), 256'(0));
        @(negedge clk);
        chk("ms_done",   256'(done), 256'(1));
        chk("ms_tap0",   256'(tap(0)), 256'(13));
`ifdef CIRC_SHREG_POS_EN
        chk("ms_pos",    256'(pos), 256'(12));
`endif

        // Insert-only
        send(4'd0, 1'b1, 1'b0, 32'hAA, 0);
        chk("ins_done",  256'(done), 256'(1));
        chk("ins_slot15", 256'(tap(5)), 256'(32'hAA));
        chk("ins_tap0",  256'(tap(0)), 256'(13));
        chk("ins_tap1",  256'(tap(1)), 256'(10));

        // Wrap: pos 12 + 5 -> 1
        send(4'd5, 1'b0, 1'b0, '0, 0);
        chk("wrap_done", 256'(done), 256'(1));
`ifdef CIRC_SHREG_POS_EN
        chk("wrap_pos",  256'(pos), 256'(1));
        chk("wrap_wrap", 256'(wrap), 256'(1));
`endif

        // Abort: reset on the second step of a 3-step command
        send(4'd12, 1'b1, 1'b0, 32'h55, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_taps",  256'(tap_data), 256'(0));
        chk("abort_done",  256'(done), 256'(0));
        chk("abort_ready", 256'(cmd_ready), 256'(1));
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_nodone", 256'(done), 256'(0));

        // Random commands
        for (int n = 0; n < 400; n++) begin
            send(4'($urandom_range(0, DP - 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0), $urandom, $urandom_range(0, 2));
        end
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
